// File: rtl/reed_generator.sv
// Reed-sensor emulator that generates one stable pulse per programmable revolution period.
// Optional contact bounce precedes each pulse. Golden revolution and distance counters are kept.
module reed_generator #(
    parameter int unsigned PULSE_WIDTH  = 4,
    parameter int unsigned BOUNCE_COUNT = 3,
    parameter int unsigned PERIOD_W     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                bounce_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          circ,
    output logic                reed,
    output logic [15:0]         rev_count,
    output logic [23:0]         dist_cm,
    output logic                active
);

    typedef enum logic [1:0] {StIdle, StBounce, StHigh, StWait} state_e;

    localparam int unsigned BurstLen = 2 * BOUNCE_COUNT;
    localparam logic [PERIOD_W-1:0] ActPlain  = PERIOD_W'(PULSE_WIDTH);
    localparam logic [PERIOD_W-1:0] ActBounce = PERIOD_W'(PULSE_WIDTH + BurstLen);
    localparam logic [PERIOD_W-1:0] BurstEnd  = PERIOD_W'(BurstLen);

    state_e              state_q, state_d;
    logic                reed_q, reed_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                bnc_q, bnc_d;
    logic [15:0]         rev_q, rev_d;
    logic [23:0]         dist_q, dist_d;

    logic                start;
    logic                hit;
    logic [PERIOD_W-1:0] act_cur;
    logic [PERIOD_W-1:0] act_new;
    logic [24:0]         dist_sum;

    always_comb begin
        state_d  = state_q;
        reed_d   = reed_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        bnc_d    = bnc_q;
        rev_d    = rev_q;
        dist_d   = dist_q;
        start    = 1'b0;
        hit      = 1'b0;
        act_cur  = bnc_q ? ActBounce : ActPlain;
        act_new  = bounce_en ? ActBounce : ActPlain;
        dist_sum = {1'b0, dist_q} + {17'd0, circ};

        if (!enable || period == '0) begin
            state_d = StIdle;
            reed_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: start = 1'b1;
                StBounce: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BurstEnd) begin
                        state_d = StHigh;
                        reed_d  = 1'b1;
                        hit     = 1'b1;
                    end else begin
                        // cnt_q counts the cycle just finished; odd cycles are glitch highs
                        reed_d = ~cnt_q[0];
                    end
                end
                StHigh: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == act_cur) begin
                        state_d = StWait;
                        reed_d  = 1'b0;
                    end
                end
                StWait: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == per_q) start = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end

        if (start) begin
            cnt_d  = {{(PERIOD_W-1){1'b0}}, 1'b1};
            bnc_d  = bounce_en;
            per_d  = (period > act_new) ? period : act_new + 1'b1;
            reed_d = 1'b1;
            if (bounce_en && BOUNCE_COUNT > 0) begin
                state_d = StBounce;
            end else begin
                state_d = StHigh;
                hit     = 1'b1;
            end
        end

        if (hit) begin
            rev_d  = rev_q + 16'd1;
            dist_d = dist_sum[24] ? 24'hff_ffff : dist_sum[23:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            reed_q  <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
            bnc_q   <= 1'b0;
            rev_q   <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            reed_q  <= reed_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            bnc_q   <= bnc_d;
            rev_q   <= rev_d;
            dist_q  <= dist_d;
        end
    end

    assign reed      = reed_q;
    assign rev_count = rev_q;
    assign dist_cm   = dist_q;
    assign active    = (state_q != StIdle);

endmodule

// File: tb/tb_reed_generator.sv
// Bench for reed_generator: directed scenarios plus random stimulus, compared every cycle
// against a revolution-position model.
module tb_reed_generator;

    localparam int PW = 4;
    localparam int BC = 3;
    localparam int DMAX = 16777215;

    logic        clock = 1'b0;
    logic        reset, enable, bounce_en;
    logic [15:0] period;
    logic [7:0]  circ;
    logic        reed, active;
    logic [15:0] rev_count;
    logic [23:0] dist_cm;

    reed_generator #(.PULSE_WIDTH(PW), .BOUNCE_COUNT(BC), .PERIOD_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .bounce_en (bounce_en),
        .period    (period),
        .circ      (circ),
        .reed      (reed),
        .rev_count (rev_count),
        .dist_cm   (dist_cm),
        .active    (active)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model: position m_i (1-based) inside the current revolution of length m_p.
    bit m_run, m_b;
    int m_i, m_p, m_rev, m_dist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int act_len(bit b);
        return PW + (b ? 2 * BC : 0);
    endfunction

    function automatic bit exp_reed();
        if (!m_run) return 1'b0;
        if (m_b && m_i <= 2 * BC) return (m_i % 2) == 1;
        return m_i <= act_len(m_b);
    endfunction

    task automatic model_update();
        if (reset) begin
            m_run = 0; m_i = 0; m_p = 0; m_b = 0; m_rev = 0; m_dist = 0;
        end else if (!enable || period == 0) begin
            m_run = 0; m_i = 0;
        end else begin
            if (!m_run || m_i == m_p) begin
                m_run = 1;
                m_i   = 1;
                m_b   = bounce_en;
                m_p   = (int'(period) > act_len(bounce_en)) ? int'(period) : act_len(bounce_en) + 1;
            end else begin
                m_i++;
            end
            if (m_i == (m_b ? 2 * BC + 1 : 1)) begin
                m_rev  = (m_rev + 1) % 65536;
                m_dist = (m_dist + int'(circ) > DMAX) ? DMAX : m_dist + int'(circ);
            end
        end
    endtask

    // Inputs are set at the negedge before calling; outputs sampled 1 time unit after posedge.
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check("reed", {31'd0, reed}, {31'd0, exp_reed()});
        check("active", {31'd0, active}, {31'd0, m_run});
        check("rev_count", {16'd0, rev_count}, m_rev);
        check("dist_cm", {8'd0, dist_cm}, m_dist);
        @(negedge clock);
    endtask

    task automatic preload(input int r, input int d);
        force dut.rev_q = r[15:0];
        force dut.dist_q = d[23:0];
        #1;
        release dut.rev_q;
        release dut.dist_q;
        m_rev  = r;
        m_dist = d;
    endtask

    initial begin
        reset = 1; enable = 0; bounce_en = 0; period = 0; circ = 0;
        m_run = 0; m_b = 0; m_i = 0; m_p = 0; m_rev = 0; m_dist = 0;
        @(negedge clock);
        repeat (5) step();
        reset = 0;

        // Basic train: P=10, no bounce
        enable = 1; period = 10; circ = 255;
        repeat (21) step();
        check("plan_rev3", {16'd0, rev_count}, 3);
        check("plan_dist765", {8'd0, dist_cm}, 765);
        repeat (6) step();
        // Period change mid-WAIT takes effect next revolution
        period = 30;
        repeat (70) step();

        // Clamp: period 3 -> P=5
        period = 3;
        repeat (20) step();

        // Bounce bursts
        bounce_en = 1; period = 20;
        repeat (60) step();

        // Abort on 2nd HIGH cycle, then re-enable
        bounce_en = 0; period = 10;
        for (int n = 0; n < 50 && !(m_run && !m_b && m_i == 2); n++) step();
        check("abort_reached", {31'd0, (m_run && !m_b && m_i == 2)}, 1);
        enable = 0;
        step();
        check("abort_active", {31'd0, active}, 0);
        enable = 1;
        step();
        check("restart_reed", {31'd0, reed}, 1);

        // Saturation and wrap from a preloaded state
        enable = 0;
        step();
        preload(65534, DMAX - 300);
        enable = 1; period = 5; circ = 255;
        repeat (20) step();
        check("dist_sat", {8'd0, dist_cm}, DMAX);
        check("rev_wrap", {16'd0, rev_count}, 2);

        // Reset in the middle of a bounce burst
        bounce_en = 1; period = 20; enable = 0;
        step();
        enable = 1;
        repeat (3) step();
        reset = 1;
        step();
        check("rst_reed", {31'd0, reed}, 0);
        check("rst_rev", {16'd0, rev_count}, 0);
        check("rst_dist", {8'd0, dist_cm}, 0);
        reset = 0;

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) period = 16'($urandom_range(0, 25));
            if ($urandom_range(0, 19) == 0) bounce_en = 1'($urandom_range(0, 1));
            circ  = 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
